// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads instruction words (and the immediate word
// of mvi) from a synchronous ROM, issues a one-cycle run pulse to the datapath,
// then waits for done before advancing the program counter.
module instr_fetch #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned LAST_ADDR = 31,
  parameter logic [2:0]  MVI_OP    = 3'b001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_INS = 3'd1,
    RD_IMM = 3'd2,
    ISSUE  = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [1:0]        WAIT_LAST = 2'(ROM_LAT);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n, addr, addr_n;
  logic [DATA_W-1:0]   din_n, instr, instr_n, imm, imm_n;
  logic                run_n, err_n;
  logic [1:0]          cnt, cnt_n;
  logic                cur_mvi, rom_mvi;
  logic [ADDR_W-1:0]   pc_inc1, pc_inc2;

  assign cur_mvi = (instr[DATA_W-1 -: 3] == MVI_OP);
  assign rom_mvi = (rom_q[DATA_W-1 -: 3] == MVI_OP);
  assign pc_inc1 = pc + ADDR_W'(1);
  assign pc_inc2 = pc + ADDR_W'(2);

  assign rom_addr  = addr;
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);
  assign fsm_state = state;

  // State register and all datapath registers; reset discards any pending read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= '0;
      addr  <= '0;
      din   <= '0;
      run   <= 1'b0;
      err   <= 1'b0;
      instr <= '0;
      imm   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      din   <= din_n;
      run   <= run_n;
      err   <= err_n;
      instr <= instr_n;
      imm   <= imm_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and next-register values; run is registered, so it is raised on
  // the transition into ISSUE and drops automatically on the way out.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    din_n   = din;
    run_n   = 1'b0;
    err_n   = err;
    instr_n = instr;
    imm_n   = imm;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RD_INS;
          addr_n  = pc;
          cnt_n   = '0;
        end
      end
      RD_INS: begin
        if (cnt == WAIT_LAST) begin
          instr_n = rom_q;
          cnt_n   = '0;
          if (rom_mvi && pc == LAST) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else if (rom_mvi) begin
            addr_n  = pc_inc1;
            state_n = RD_IMM;
          end else begin
            din_n   = rom_q;
            run_n   = 1'b1;
            state_n = ISSUE;
          end
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      RD_IMM: begin
        if (cnt == WAIT_LAST) begin
          imm_n   = rom_q;
          din_n   = instr;
          run_n   = 1'b1;
          cnt_n   = '0;
          state_n = ISSUE;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      ISSUE: begin
        din_n   = cur_mvi ? imm : instr;
        state_n = EXEC;
      end
      EXEC: begin
        if (done) begin
          if ((cur_mvi ? pc_inc1 : pc) == LAST) begin
            state_n = HALT;
          end else begin
            pc_n    = cur_mvi ? pc_inc2 : pc_inc1;
            addr_n  = cur_mvi ? pc_inc2 : pc_inc1;
            cnt_n   = '0;
            state_n = RD_INS;
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
